seg7_scan_ctrl: RTL

Parametrised multi-digit 7-segment display controller for the board wrapper. It accepts a binary word plus a valid strobe and converts it to hex or decimal. Decimal conversion is signed or unsigned and uses a sequential shift-add-3 converter. The controller time-multiplexes the result across DIGITS common-anode digits, with leading-zero blanking, minus-sign placement and overflow indication. It replaces the fixed 4-digit temperature-only display driver and is fed from any board-level source, such as sensor data or GPIO.

---
 rtl/seg7_pkg.sv | 59 +++++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/seg7_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared segment codes, FSM/mode types and the nibble-to-segment decoder
// for the seg7_scan_ctrl display controller.
package seg7_pkg;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_t;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle,
// DATA_W cycles after start_i; done_o flags the cycle of the final step.
module bin2bcd_seq #(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = (DATA_W * 3) / 10 + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       bin_i,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            // The adjusted top bit is never set for in-range inputs, so it is dropped here
            bin_d = bin_q << 1;
            bcd_d = BCD_W'({bcd_adj, bin_q[DATA_W-1]});
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit 7-segment controller: hex/decimal conversion, commit, scan.
// Optional macro SEG7_SCAN_BRIGHTNESS_EN adds bright_i PWM of the anodes.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int DATA_W     = 16,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic              mode_i,
    input  logic              signed_i,
    input  logic              blank_lz_i,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    input  logic [3:0]        bright_i,
`endif
    output logic              busy_o,
    output logic              overflow_o,
    output logic [6:0]        seg_o,
    output logic              dp_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 1;
    localparam int P_RAW      = CLK_HZ / (REFRESH_HZ * DIGITS) - 1;
    localparam int P          = (P_RAW < 0) ? 0 : P_RAW;
    localparam int PW         = (P > 0) ? $clog2(P + 1) : 1;
    localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int EXT_N      = 16;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q;
    logic                ovf_q;
    logic [6:0]          disp_q [DIGITS];
    logic [6:0]          disp_d [DIGITS];
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                cvt_start;
    logic                cvt_done;
    logic [DATA_W-1:0]   magnitude;
    logic [4*BCD_DIGITS-1:0] bcd;

    assign magnitude = (signed_i && data_i[DATA_W-1]) ? -data_i : data_i;
    assign cvt_start = (state_q == ST_IDLE) && data_valid_i && mode_i;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (cvt_start),
        .bin_i   (magnitude),
        .done_o  (cvt_done),
        .bcd_o   (bcd)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (data_valid_i) begin
                    mode_d  = mode_t'(mode_i);
                    data_d  = data_i;
                    neg_d   = mode_i & signed_i & data_i[DATA_W-1];
                    state_d = mode_i ? ST_CONVERT : ST_COMMIT;
                end
            end
            ST_CONVERT: if (cvt_done) state_d = ST_COMMIT;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Display image built from the latched value; written only during COMMIT
    logic [4*EXT_N-1:0] hex_ext, bcd_ext, sel_ext;
    logic               ovf_calc;
    int                 nsig;
    int                 minus_pos;

    always_comb begin
        hex_ext                    = '0;
        hex_ext[DATA_W-1:0]        = data_q;
        bcd_ext                    = '0;
        bcd_ext[4*BCD_DIGITS-1:0]  = bcd;
        sel_ext = (mode_q == MODE_DEC) ? bcd_ext : hex_ext;
        nsig = 1;
        for (int k = 1; k < EXT_N; k++) begin
            if (sel_ext[4*k +: 4] != 4'd0) nsig = k + 1;
        end
        if (mode_q == MODE_DEC) ovf_calc = (nsig + int'(neg_q)) > DIGITS;
        else                    ovf_calc = |(hex_ext >> (4 * DIGITS));
        minus_pos = blank_lz_i ? nsig : DIGITS - 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_calc)                     disp_d[k] = SEG_MINUS;
            else if (neg_q && k == minus_pos) disp_d[k] = SEG_MINUS;
            else if (blank_lz_i && k >= nsig) disp_d[k] = SEG_BLANK;
            else                              disp_d[k] = nibble_to_seg(sel_ext[4*k +: 4]);
        end
    end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    int on_cycles;
`endif

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(P)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        an_d        = '1;
        an_d[idx_q] = 1'b0;
        seg_d       = disp_q[idx_q];
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        on_cycles = ((P + 1) * (int'(bright_i) + 1)) >> 4;
        if (on_cycles < 1) on_cycles = 1;
        if (int'(presc_q) >= on_cycles) an_d = '1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HEX;
            neg_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < DIGITS; k++) disp_q[k] <= SEG_BLANK;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            data_q  <= data_d;
            busy_q  <= (state_d != ST_IDLE);
            if (state_q == ST_COMMIT) begin
                ovf_q <= ovf_calc;
                for (int k = 0; k < DIGITS; k++) disp_q[k] <= disp_d[k];
            end
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign seg_o      = seg_q;
    assign dp_o       = 1'b1;
    assign an_o       = an_q;

endmodule
